// File: rtl/lock_pkg.sv
// Shared types and constants for the parameterised BCD password lock.
package lock_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] ERR_CODE = 4'hE;

  typedef enum logic [1:0] {
    StEntry,
    StCheck,
    StLockout
  } lock_state_e;

endpackage

// File: rtl/lockout_timer.sv
// Lockout duration counter with a free-running LED flasher; done pulses in the last lockout cycle.
module lockout_timer #(
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned FLASH_HALF     = 64
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  output logic led,
  output logic done
);

  localparam int unsigned TW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned HW = $clog2(FLASH_HALF + 1);

  logic          active_q, active_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] ph_q, ph_d;
  logic          led_q, led_d;

  assign done = active_q && (cnt_q == TW'(LOCKOUT_CYCLES - 1));
  assign led  = led_q;

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    ph_d     = ph_q;
    led_d    = led_q;
    if (start) begin
      active_d = 1'b1;
      cnt_d    = '0;
      ph_d     = '0;
      led_d    = 1'b1;
    end else if (done) begin
      active_d = 1'b0;
      cnt_d    = '0;
      ph_d     = '0;
      led_d    = 1'b0;
    end else if (active_q) begin
      cnt_d = cnt_q + TW'(1);
      if (ph_q == HW'(FLASH_HALF - 1)) begin
        ph_d  = '0;
        led_d = ~led_q;
      end else begin
        ph_d = ph_q + HW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      ph_q     <= '0;
      led_q    <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ph_q     <= ph_d;
      led_q    <= led_d;
    end
  end

endmodule

// File: rtl/param_lock_controller.sv
// BCD keypad lock: programs passwords into slots, checks unlock attempts against all valid
// slots in one cycle, and enforces a timed lockout after repeated failures.
module param_lock_controller
  import lock_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter int unsigned NUM_SLOTS      = 4,
  parameter int unsigned MAX_ERRORS     = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned FLASH_HALF     = 64,
  localparam int unsigned SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
  localparam int unsigned CW = $clog2(NUM_DIGITS + 1),
  localparam int unsigned BW = DIGIT_W * NUM_DIGITS
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               mode,
  input  logic [SW-1:0]      slot_sel,
  input  logic [DIGIT_W-1:0] digit_in,
  input  logic               digit_valid,
  input  logic               enter,
  input  logic               cancel,
  output logic [BW-1:0]      disp,
  output logic [CW-1:0]      digit_count,
  output logic               prog_ok,
  output logic               prog_err,
  output logic               unlock_ok,
  output logic               unlock_fail,
  output logic [3:0]         err_count,
  output logic               locked_out,
  output logic               led
);

  localparam logic [CW-1:0] Full   = CW'(NUM_DIGITS);
  localparam logic [3:0]    MaxErr = 4'(MAX_ERRORS);

  lock_state_e state_q, state_d;
  logic        mode_q;

  logic [BW-1:0] buf_q, buf_d, cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d, cand_cnt_q, cand_cnt_d;
  logic          bad_q, bad_d, cand_bad_q, cand_bad_d;

  logic [BW-1:0]        slot_q [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] valid_q;
  logic [NUM_SLOTS-1:0] hit;
  logic                 slot_we;
  logic                 slot_in_range;
  logic                 match;

  logic [3:0] err_q, err_d, err_inc;
  logic       prog_ok_q, prog_ok_d, prog_err_q, prog_err_d;
  logic       unl_ok_q, unl_ok_d, unl_fail_q, unl_fail_d;
  logic       timer_start, timer_done;

  assign slot_in_range = 32'(slot_sel) < NUM_SLOTS;
  assign err_inc       = err_q + 4'd1;

  // Invalid slots are masked so a cleared slot of zeros can never match.
  always_comb begin
    for (int s = 0; s < NUM_SLOTS; s++) begin
      hit[s] = valid_q[s] && (slot_q[s] == cand_q);
    end
  end

  assign match = (cand_cnt_q == Full) && !cand_bad_q && (|hit);

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    bad_d       = bad_q;
    cand_d      = cand_q;
    cand_cnt_d  = cand_cnt_q;
    cand_bad_d  = cand_bad_q;
    err_d       = err_q;
    slot_we     = 1'b0;
    prog_ok_d   = 1'b0;
    prog_err_d  = 1'b0;
    unl_ok_d    = 1'b0;
    unl_fail_d  = 1'b0;
    timer_start = 1'b0;

    unique case (state_q)
      StEntry: begin
        if (cancel || (mode != mode_q)) begin
          buf_d = '0;
          cnt_d = '0;
          bad_d = 1'b0;
        end else if (enter) begin
          if (!mode) begin
            if ((cnt_q == Full) && !bad_q && slot_in_range) begin
              slot_we   = 1'b1;
              prog_ok_d = 1'b1;
            end else begin
              prog_err_d = 1'b1;
            end
          end else begin
            cand_d     = buf_q;
            cand_cnt_d = cnt_q;
            cand_bad_d = bad_q;
            state_d    = StCheck;
          end
          buf_d = '0;
          cnt_d = '0;
          bad_d = 1'b0;
        end else if (digit_valid && (cnt_q != Full)) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
              buf_d[i*DIGIT_W +: DIGIT_W] = (digit_in > 4'd9) ? ERR_CODE : digit_in;
            end
          end
          cnt_d = cnt_q + CW'(1);
          if (digit_in > 4'd9) begin
            bad_d = 1'b1;
          end
        end
      end
      StCheck: begin
        if (match) begin
          unl_ok_d = 1'b1;
          err_d    = '0;
          state_d  = StEntry;
        end else begin
          unl_fail_d = 1'b1;
          err_d      = err_inc;
          if (err_inc == MaxErr) begin
            timer_start = 1'b1;
            state_d     = StLockout;
          end else begin
            state_d = StEntry;
          end
        end
      end
      StLockout: begin
        if (timer_done) begin
          err_d   = '0;
          state_d = StEntry;
        end
      end
      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= StEntry;
      mode_q     <= 1'b0;
      buf_q      <= '0;
      cnt_q      <= '0;
      bad_q      <= 1'b0;
      cand_q     <= '0;
      cand_cnt_q <= '0;
      cand_bad_q <= 1'b0;
      err_q      <= '0;
      prog_ok_q  <= 1'b0;
      prog_err_q <= 1'b0;
      unl_ok_q   <= 1'b0;
      unl_fail_q <= 1'b0;
      valid_q    <= '0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        slot_q[s] <= '0;
      end
    end else begin
      state_q    <= state_d;
      mode_q     <= mode;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      bad_q      <= bad_d;
      cand_q     <= cand_d;
      cand_cnt_q <= cand_cnt_d;
      cand_bad_q <= cand_bad_d;
      err_q      <= err_d;
      prog_ok_q  <= prog_ok_d;
      prog_err_q <= prog_err_d;
      unl_ok_q   <= unl_ok_d;
      unl_fail_q <= unl_fail_d;
      if (slot_we) begin
        slot_q[slot_sel]  <= buf_q;
        valid_q[slot_sel] <= 1'b1;
      end
    end
  end

  lockout_timer #(
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES),
    .FLASH_HALF    (FLASH_HALF)
  ) u_lockout_timer (
    .clk  (clk),
    .clr  (clr),
    .start(timer_start),
    .led  (led),
    .done (timer_done)
  );

  assign disp        = buf_q;
  assign digit_count = cnt_q;
  assign prog_ok     = prog_ok_q;
  assign prog_err    = prog_err_q;
  assign unlock_ok   = unl_ok_q;
  assign unlock_fail = unl_fail_q;
  assign err_count   = err_q;
  assign locked_out  = (state_q == StLockout);

endmodule

// File: doc/param_lock_controller.md
PARAM_LOCK_CONTROLLER -- requirements
Module: param_lock_controller

Interface
REQ-001 SHALL have parameter NUM_DIGITS, 6, password length in BCD digits (2..16).
REQ-002 SHALL have parameter NUM_SLOTS, 4, number of stored passwords (1..8).
REQ-003 SHALL have parameter MAX_ERRORS, 3, consecutive failed unlocks that trigger lockout (1..15).
REQ-004 SHALL have parameter LOCKOUT_CYCLES, 1024, lockout duration in clk cycles.
REQ-005 SHALL have parameter FLASH_HALF, 64, LED half-period in clk cycles during lockout.
REQ-006 SHALL have the following ports, clock and reset first:
- clk  in  1  system clock; single clock domain, all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- mode  in  1  0 = program password, 1 = unlock attempt.
- slot_sel  in  SW = max(1, clog2(NUM_SLOTS))  slot written in program mode.
- digit_in  in  4  BCD digit.
- digit_valid  in  1  single-cycle digit strobe.
- enter  in  1  single-cycle commit strobe.
- cancel  in  1  single-cycle clear-entry strobe.
- disp  out  4*NUM_DIGITS  entered digits; digit 0 in bits [3:0].
- digit_count  out  clog2(NUM_DIGITS+1)  digits currently held.
- prog_ok / prog_err  out  1 each  one-cycle program result pulses.
- unlock_ok / unlock_fail  out  1 each  one-cycle unlock result pulses.
- err_count  out  4  consecutive failed unlocks.
- locked_out  out  1  high for the whole lockout.
- led  out  1  flashes during lockout, otherwise 0.

Function
REQ-007 SHALL implement states ENTRY, CHECK, LOCKOUT; ENTRY is the reset state.
REQ-008 In ENTRY, an accepted digit_valid SHALL store the digit at position digit_count and increment digit_count; a strobe with digit_count == NUM_DIGITS SHALL be ignored.
REQ-009 digit_in > 9 SHALL be stored and displayed as 4'hE and SHALL set a sticky bad flag for the current entry.
REQ-010 Same-cycle priority SHALL be cancel > enter > digit_valid; a dropped digit SHALL NOT be stored.
REQ-011 cancel, or any change of mode sampled between cycles, SHALL clear disp, digit_count and the bad flag without producing any pulse.
REQ-012 enter with mode=0 SHALL, on the same edge, write the entry into slot slot_sel, mark that slot valid and pulse prog_ok, if digit_count == NUM_DIGITS and bad is clear and slot_sel < NUM_SLOTS; otherwise it SHALL pulse prog_err and leave the slots unchanged; the buffer SHALL clear in both cases.
REQ-013 enter with mode=1 SHALL latch the entry, clear the buffer and go to CHECK; CHECK SHALL last exactly one cycle and compare against all valid slots in parallel.
REQ-014 Match SHALL require digit_count == NUM_DIGITS, bad clear, and equality with at least one valid slot; invalid slots SHALL never match.
REQ-015 On the edge leaving CHECK: match -> unlock_ok pulse, err_count = 0, return to ENTRY; otherwise -> unlock_fail pulse and err_count + 1, then LOCKOUT if the new count == MAX_ERRORS, else ENTRY.
REQ-016 Result pulses SHALL therefore appear two edges after the enter edge and last exactly one cycle.
REQ-017 In LOCKOUT, locked_out SHALL be 1 and all digit, enter and cancel inputs SHALL be ignored.
REQ-018 In LOCKOUT, led SHALL start at 1 and toggle every FLASH_HALF cycles.
REQ-019 After LOCKOUT_CYCLES cycles in LOCKOUT, the block SHALL clear err_count, set led = 0 and locked_out = 0, and return to ENTRY.
REQ-020 err_count SHALL never exceed MAX_ERRORS.
REQ-021 Program results SHALL NOT change err_count.

Reset
REQ-022 clr SHALL, asynchronously, clear all slots and valid bits, disp, digit_count, the bad flag, err_count, all pulses, locked_out, led and the timers, and force state ENTRY; reset during CHECK or LOCKOUT SHALL produce no result pulse.

Structure
REQ-023 Package lock_pkg SHALL hold the state enum, the DIGIT_W = 4 constant and the ERR_CODE = 4'hE constant.
REQ-024 The lockout duration counter and LED toggle SHALL be a sub-module lockout_timer with inputs start and clk/clr and outputs led and done.

Verification (NUM_DIGITS=6, NUM_SLOTS=4, MAX_ERRORS=3, LOCKOUT_CYCLES=16, FLASH_HALF=2)
REQ-025 Program slot 2 with 1,2,3,4,5,6, then unlock with 123456 -> prog_ok pulse; unlock_ok two edges after enter; err_count = 0.
REQ-026 Unlock with 123456 after reset, when no slot is valid -> unlock_fail; err_count = 1.
REQ-027 Three wrong unlocks of 000000 -> err_count = 3 and locked_out = 1 for exactly 16 cycles; led pattern 1,1,0,0,...; digits are ignored during lockout; afterwards err_count = 0.
REQ-028 Program with 5 digits, or with digit value 4'hB -> prog_err; disp shows E in the bad position; a later unlock with the same digits fails.
REQ-029 Enter 7 digits then enter -> the 7th digit is ignored and digit_count stays at 6; enter and digit_valid in the same cycle -> the digit is dropped.
REQ-030 Assert clr during CHECK -> no unlock pulse; all outputs read 0 and all slots are invalid.
